// File: rtl/branch_stats_pkg.sv
// rtl/branch_stats_pkg.sv - register map, CTRL bit positions and helpers for branch statistics
package branch_stats_pkg;

  // Word index of each Wishbone-visible register (byte address bits [3:2])
  typedef enum logic [1:0] {
    REG_TOTAL   = 2'd0,
    REG_TAKEN   = 2'd1,
    REG_MISPRED = 2'd2,
    REG_CTRL    = 2'd3
  } reg_idx_e;

  // Bit positions inside the CTRL register
  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_OVF    = 2;

  // Number of set bits across the two retire lanes (0..2)
  function automatic logic [1:0] popcount2(input logic [1:0] lanes);
    return {1'b0, lanes[0]} + {1'b0, lanes[1]};
  endfunction

endpackage

// File: rtl/branch_stat_cnt.sv
// rtl/branch_stat_cnt.sv - one event counter with 0..2 increment, clear and overflow pulse
module branch_stat_cnt
  import branch_stats_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       inc,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] next_count;
  logic             carry;

  // Sum in WIDTH+1 bits so the carry-out flags overflow; clamp or wrap on carry
  always_comb begin
    sum        = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};
    carry      = sum[WIDTH];
    next_count = sum[WIDTH-1:0];
    if (carry && SATURATE) begin
      next_count = {WIDTH{1'b1}};
    end
    // A clear on the same edge discards the increment, so it cannot overflow either
    ovf = en & ~clr & carry;
  end

  // Counter register: clear wins over a same-edge increment; hold when disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (inc != 2'd0)) begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/branch_stats_counter.sv
// rtl/branch_stats_counter.sv - retired/taken/mispredicted branch counters with Wishbone access
module branch_stats_counter
  import branch_stats_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       i_br_valid,
  input  logic [1:0]       i_br_taken,
  input  logic [1:0]       i_br_mispred,
  input  logic [1:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  output logic [WIDTH-1:0] o_branches_counter,
  output logic [WIDTH-1:0] o_branches_taken_counter
);

  logic [1:0]       valid_q;
  logic [1:0]       taken_q;
  logic [1:0]       mispred_q;
  logic             freeze;
  logic             ovf_flag;
  logic             req;
  logic             wr_ctrl;
  logic             clear;
  logic             ovf_w1c;
  logic             ovf_any;
  logic             ovf_total;
  logic             ovf_taken;
  logic             ovf_mispred;
  logic [WIDTH-1:0] total_cnt;
  logic [WIDTH-1:0] taken_cnt;
  logic [WIDTH-1:0] mispred_cnt;
  logic [31:0]      read_data;
  logic             unused_wb_dat;

  assign unused_wb_dat = ^i_wb_dat[31:3];

  // A new request is accepted only while no ack is outstanding
  assign req     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr_ctrl = req & i_wb_we & (i_wb_adr == REG_CTRL);
  assign clear   = wr_ctrl & i_wb_dat[CTRL_CLEAR];
  assign ovf_w1c = wr_ctrl & i_wb_dat[CTRL_OVF];
  assign ovf_any = ovf_total | ovf_taken | ovf_mispred;

  // Stage 1: capture retire lanes every cycle, masking qualifiers with valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q   <= 2'b00;
      taken_q   <= 2'b00;
      mispred_q <= 2'b00;
    end else begin
      valid_q   <= i_br_valid;
      taken_q   <= i_br_taken & i_br_valid;
      mispred_q <= i_br_mispred & i_br_valid;
    end
  end

  // Stage 2: three counters, gated by FREEZE and zeroed by CLEAR
  branch_stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_total (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (popcount2(valid_q)),
    .en    (~freeze),
    .clr   (clear),
    .count (total_cnt),
    .ovf   (ovf_total)
  );

  branch_stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_taken (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (popcount2(taken_q)),
    .en    (~freeze),
    .clr   (clear),
    .count (taken_cnt),
    .ovf   (ovf_taken)
  );

  branch_stat_cnt #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_mispred (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (popcount2(mispred_q)),
    .en    (~freeze),
    .clr   (clear),
    .count (mispred_cnt),
    .ovf   (ovf_mispred)
  );

  // CTRL register: FREEZE follows writes; OVF is sticky, set beats W1C, CLEAR beats both
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      freeze   <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        freeze <= i_wb_dat[CTRL_FREEZE];
      end
      if (clear) begin
        ovf_flag <= 1'b0;
      end else if (ovf_any) begin
        ovf_flag <= 1'b1;
      end else if (ovf_w1c) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  // Read mux; CLEAR is self-clearing so its bit always reads back as 0
  always_comb begin
    read_data = 32'd0;
    case (reg_idx_e'(i_wb_adr))
      REG_TOTAL:   read_data = 32'(total_cnt);
      REG_TAKEN:   read_data = 32'(taken_cnt);
      REG_MISPRED: read_data = 32'(mispred_cnt);
      REG_CTRL: begin
        read_data[CTRL_FREEZE] = freeze;
        read_data[CTRL_OVF]    = ovf_flag;
      end
      default:     read_data = 32'd0;
    endcase
  end

  // Bus response: one-cycle ack after the request edge, read data sampled on that edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
    end else begin
      o_wb_ack <= req;
      if (req) begin
        o_wb_rdt <= read_data;
      end
    end
  end

  assign o_branches_counter       = total_cnt;
  assign o_branches_taken_counter = taken_cnt;

endmodule

// File: tb/tb_branch_stats_counter.sv
// tb/tb_branch_stats_counter.sv - directed self-checking bench for branch_stats_counter
module tb_branch_stats_counter;

  logic        clk;
  logic        rstn;
  logic [1:0]  bv, bt, bm;
  logic [1:0]  sv, st, sm;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat;
  logic        wb_we, wb_cyc, wb_stb;

  logic [31:0] rdt_main, rdt_sat, rdt_wrap;
  logic        ack_main, ack_sat, ack_wrap;
  logic [31:0] tot_main, tkn_main;
  logic [3:0]  tot_sat, tkn_sat, tot_wrap, tkn_wrap;

  logic [31:0] r_main, r_sat, r_wrap;
  int          n_cmp;
  int          n_err;

  branch_stats_counter #(.WIDTH(32), .SATURATE(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .i_br_valid(bv), .i_br_taken(bt), .i_br_mispred(bm),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(rdt_main), .o_wb_ack(ack_main),
    .o_branches_counter(tot_main), .o_branches_taken_counter(tkn_main)
  );

  branch_stats_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rstn(rstn),
    .i_br_valid(sv), .i_br_taken(st), .i_br_mispred(sm),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(rdt_sat), .o_wb_ack(ack_sat),
    .o_branches_counter(tot_sat), .o_branches_taken_counter(tkn_sat)
  );

  branch_stats_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .i_br_valid(sv), .i_br_taken(st), .i_br_mispred(sm),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(rdt_wrap), .o_wb_ack(ack_wrap),
    .o_branches_counter(tot_wrap), .o_branches_taken_counter(tkn_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
    wb_adr = adr; wb_dat = dat; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick();
    check("wr_ack_high", {31'd0, ack_main}, 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [1:0] adr);
    wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick();
    check("rd_ack_high", {31'd0, ack_main}, 32'd1);
    r_main = rdt_main; r_sat = rdt_sat; r_wrap = rdt_wrap;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();
    check("rd_ack_low", {31'd0, ack_main}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rstn = 1'b0;
    bv = 2'b00; bt = 2'b00; bm = 2'b00;
    sv = 2'b00; st = 2'b00; sm = 2'b00;
    wb_adr = 2'd0; wb_dat = 32'd0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(); tick();

    // reset state
    check("rst_total", tot_main, 32'd0);
    check("rst_taken", tkn_main, 32'd0);
    check("rst_ack",   {31'd0, ack_main}, 32'd0);
    check("rst_rdt",   rdt_main, 32'd0);
    rstn = 1'b1;
    tick();

    // 1: single lane0 taken branch, two-edge latency
    bv = 2'b01; bt = 2'b01;
    tick();
    bv = 2'b00; bt = 2'b00;
    check("t1_not_yet", tot_main, 32'd0);
    tick();
    check("t1_total", tot_main, 32'd1);
    check("t1_taken", tkn_main, 32'd1);
    wb_read(2'd2);
    check("t1_mispred", r_main, 32'd0);

    // 2: dual lane, lane1 taken+mispred, 10 cycles
    for (int i = 0; i < 10; i++) begin
      bv = 2'b11; bt = 2'b10; bm = 2'b10;
      tick();
    end
    bv = 2'b00; bt = 2'b00; bm = 2'b00;
    tick(); tick();
    check("t2_total", tot_main, 32'd21);
    check("t2_taken", tkn_main, 32'd11);
    wb_read(2'd2);
    check("t2_mispred", r_main, 32'd10);
    wb_read(2'd0);
    check("t2_total_rd", r_main, 32'd21);

    // 3: qualifiers without valid are ignored
    for (int i = 0; i < 5; i++) begin
      bv = 2'b00; bt = 2'b11; bm = 2'b11;
      tick();
    end
    bt = 2'b00; bm = 2'b00;
    tick(); tick();
    check("t3_total", tot_main, 32'd21);
    check("t3_taken", tkn_main, 32'd11);

    // 4: freeze holds counters, unfreeze resumes
    wb_write(2'd3, 32'h1);
    for (int i = 0; i < 8; i++) begin
      bv = 2'b11; bt = 2'b11;
      tick();
    end
    bv = 2'b00; bt = 2'b00;
    tick(); tick();
    check("t4_frozen_total", tot_main, 32'd21);
    check("t4_frozen_taken", tkn_main, 32'd11);
    wb_read(2'd3);
    check("t4_ctrl_freeze", r_main, 32'h1);
    wb_write(2'd3, 32'h0);
    bv = 2'b01;
    tick();
    bv = 2'b00;
    tick(); tick();
    check("t4_resume_total", tot_main, 32'd22);
    check("t4_resume_taken", tkn_main, 32'd11);

    // 5: overflow on 4-bit instances: 14 + 2 -> clamp / wrap
    for (int i = 0; i < 7; i++) begin
      sv = 2'b11;
      tick();
    end
    sv = 2'b00;
    tick(); tick();
    check("t5_sat_pre",  {28'd0, tot_sat},  32'd14);
    check("t5_wrap_pre", {28'd0, tot_wrap}, 32'd14);
    wb_read(2'd3);
    check("t5_ovf_clear_pre", r_sat, 32'h0);
    sv = 2'b11;
    tick();
    sv = 2'b00;
    tick(); tick();
    check("t5_sat_total",  {28'd0, tot_sat},  32'd15);
    check("t5_wrap_total", {28'd0, tot_wrap}, 32'd0);
    check("t5_sat_taken",  {28'd0, tkn_sat},  32'd0);
    sv = 2'b01;
    tick();
    sv = 2'b00;
    tick(); tick();
    check("t5_sat_hold", {28'd0, tot_sat},  32'd15);
    check("t5_wrap_one", {28'd0, tot_wrap}, 32'd1);
    wb_read(2'd3);
    check("t5_sat_ovf",  r_sat,  32'h4);
    check("t5_wrap_ovf", r_wrap, 32'h4);
    check("t5_main_ovf", r_main, 32'h0);
    wb_write(2'd3, 32'h4);
    wb_read(2'd3);
    check("t5_sat_w1c",  r_sat,  32'h0);
    check("t5_wrap_w1c", r_wrap, 32'h0);
    wb_read(2'd0);
    check("t5_sat_rd_total", r_sat, 32'd15);

    // 6: CLEAR lands on the same edge as a dual increment; clear wins
    bv = 2'b11; bt = 2'b11; bm = 2'b11;
    tick();
    bv = 2'b00; bt = 2'b00; bm = 2'b00;
    wb_adr = 2'd3; wb_dat = 32'h2; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick();
    check("t6_ack_high", {31'd0, ack_main}, 32'd1);
    check("t6_total", tot_main, 32'd0);
    check("t6_taken", tkn_main, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick();
    check("t6_ack_low", {31'd0, ack_main}, 32'd0);
    check("t6_total_hold", tot_main, 32'd0);
    wb_read(2'd2);
    check("t6_mispred", r_main, 32'd0);
    wb_read(2'd3);
    check("t6_ctrl", r_main, 32'h0);

    // back-to-back request held high: ack on alternate cycles
    wb_adr = 2'd0; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick();
    check("b2b_ack1", {31'd0, ack_main}, 32'd1);
    tick();
    check("b2b_gap", {31'd0, ack_main}, 32'd0);
    tick();
    check("b2b_ack2", {31'd0, ack_main}, 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();

    // asynchronous reset mid-operation drops in-flight events
    bv = 2'b11; bt = 2'b11;
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    check("arst_total", tot_main, 32'd0);
    check("arst_taken", tkn_main, 32'd0);
    bv = 2'b00; bt = 2'b00;
    tick();
    rstn = 1'b1;
    tick(); tick();
    check("arst_after", tot_main, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
